// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multicycle MIPS control FSM and its datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface mc_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluctr;
  logic [1:0]       pcsrc;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, zero, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluctr, pcsrc,
           illegal, instr_cnt
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluctr, pcsrc,
           illegal, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS CPU: fetch/decode/execute/memory/writeback
// sequencing of the shared datapath, plus a retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_ctrl_fsm_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  logic             op_legal;

  // The branch decision is taken outside this block; zero is carried for the datapath only.
  logic unused_zero;
  assign unused_zero = bus.zero;

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, RWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      MEMWR:                            retire = bus.mem_ready;
      default:                          retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      if (retire) cnt <= cnt + CNT_W'(1);
      case (state)
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWR:  if (bus.mem_ready) state <= FETCH;
        EXEC:   state <= RWB;
        ADDIEX: state <= ADDIWB;
        MEMWB, RWB, BRANCH, ADDIWB, JUMP: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by rst_n so write enables stay off for the whole reset cycle,
  // not just from the edge after it is sampled.
  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.aluctr      = 2'b00;
    bus.pcsrc       = 2'b00;
    bus.illegal     = 1'b0;
    bus.instr_cnt   = '0;
    if (rst_n) begin
      bus.instr_cnt = cnt;
      case (state)
        FETCH: begin
          bus.memread = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          bus.pcwrite = bus.mem_ready;
        end
        DECODE: begin
          bus.alusrcb = 2'b11;
          bus.illegal = !op_legal;
        end
        MEMADR, ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        MEMRD: begin
          bus.memread = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        MEMWR: begin
          bus.memwrite = 1'b1;
          bus.iord     = 1'b1;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          bus.aluctr  = 2'b10;
        end
        RWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        BRANCH: begin
          bus.alusrca     = 1'b1;
          bus.aluctr      = 2'b01;
          bus.pcsrc       = 2'b01;
          bus.pcwritecond = 1'b1;
        end
        ADDIWB: bus.regwrite = 1'b1;
        JUMP: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver queues the expected control word and
// count for every cycle; the monitor pops and compares on each falling edge.
module tb_mc_ctrl_fsm;

  localparam int unsigned CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluctr,pcsrc,illegal}
  localparam logic [16:0] C_ZERO   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [16:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] C_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] C_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  typedef struct {
    string         nm;
    logic [16:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  logic [CW-1:0] ecnt;
  int unsigned checks;
  int unsigned failures;

  mc_ctrl_fsm_if #(.CNT_W(CW)) ifc ();

  mc_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] act_ctl;
  assign act_ctl = {ifc.pcwrite, ifc.pcwritecond, ifc.iord, ifc.memread, ifc.memwrite,
                    ifc.irwrite, ifc.memtoreg, ifc.regdst, ifc.regwrite, ifc.alusrca,
                    ifc.alusrcb, ifc.aluctr, ifc.pcsrc, ifc.illegal};

  // Monitor: every cycle the DUT presents a control word; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (act_ctl !== e.ctl) begin
          failures++;
          $display("FAIL %s ctl: got %b expected %b at %0t", e.nm, act_ctl, e.ctl, $time);
        end
        checks++;
        if (ifc.instr_cnt !== e.cnt) begin
          failures++;
          $display("FAIL %s instr_cnt: got %0d expected %0d at %0t", e.nm, ifc.instr_cnt, e.cnt, $time);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic rn, input logic mr, input logic [16:0] ectl,
                     input bit ret);
    exp_t e;
    rst_n         = rn;
    ifc.mem_ready = mr;
    e.nm  = nm;
    e.ctl = ectl;
    e.cnt = rn ? ecnt : '0;
    sb.push_back(e);
    if (!rn)      ecnt = '0;
    else if (ret) ecnt = ecnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] o, input int unsigned fw, input int unsigned mw);
    ifc.op = o;
    for (int unsigned i = 0; i < fw; i++) cyc("fetch_wait", 1'b1, 1'b0, C_FWAIT, 1'b0);
    cyc("fetch", 1'b1, 1'b1, C_FETCH, 1'b0);
    case (o)
      OP_R: begin
        cyc("r_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("r_exec", 1'b1, 1'b1, C_EXEC, 1'b0);
        cyc("r_rwb", 1'b1, 1'b1, C_RWB, 1'b1);
      end
      OP_LW: begin
        cyc("lw_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("lw_memadr", 1'b1, 1'b1, C_MEMADR, 1'b0);
        for (int unsigned i = 0; i < mw; i++) cyc("lw_memrd_wait", 1'b1, 1'b0, C_MEMRD, 1'b0);
        cyc("lw_memrd", 1'b1, 1'b1, C_MEMRD, 1'b0);
        cyc("lw_memwb", 1'b1, 1'b1, C_MEMWB, 1'b1);
      end
      OP_SW: begin
        cyc("sw_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("sw_memadr", 1'b1, 1'b1, C_MEMADR, 1'b0);
        for (int unsigned i = 0; i < mw; i++) cyc("sw_memwr_wait", 1'b1, 1'b0, C_MEMWR, 1'b0);
        cyc("sw_memwr", 1'b1, 1'b1, C_MEMWR, 1'b1);
      end
      OP_BEQ: begin
        cyc("beq_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("beq_branch", 1'b1, 1'b1, C_BRANCH, 1'b1);
      end
      OP_ADDI: begin
        cyc("addi_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("addi_ex", 1'b1, 1'b1, C_ADDIEX, 1'b0);
        cyc("addi_wb", 1'b1, 1'b1, C_ADDIWB, 1'b1);
      end
      OP_J: begin
        cyc("j_decode", 1'b1, 1'b1, C_DEC, 1'b0);
        cyc("j_jump", 1'b1, 1'b1, C_JUMP, 1'b1);
      end
      default: cyc("illegal_decode", 1'b1, 1'b1, C_DECILL, 1'b0);
    endcase
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    ecnt          = '0;
    rst_n         = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.zero      = 1'b0;
    ifc.op        = OP_R;
    @(posedge clk);
    #1;

    // Reset held two cycles with mem_ready high: everything quiet.
    cyc("reset0", 1'b0, 1'b1, C_ZERO, 1'b0);
    cyc("reset1", 1'b0, 1'b1, C_ZERO, 1'b0);

    // Back-to-back instructions with memory always ready.
    instr(OP_R, 0, 0);
    instr(OP_LW, 0, 0);
    instr(OP_SW, 0, 0);
    instr(OP_BEQ, 0, 0);
    instr(OP_ADDI, 0, 0);
    instr(OP_J, 0, 0);

    // lw with three fetch stalls and two read stalls.
    instr(OP_LW, 3, 2);

    // beq with zero set and clear: same strobes either way.
    ifc.zero = 1'b1;
    instr(OP_BEQ, 0, 0);
    ifc.zero = 1'b0;
    instr(OP_BEQ, 0, 0);

    // Unsupported opcode: illegal pulse, back to fetch, no retire.
    instr(OP_BAD, 0, 0);

    // Eight more retirements: count goes 9 -> 15 -> 0 -> 1.
    for (int unsigned i = 0; i < 8; i++) instr(OP_BEQ, 0, 0);

    // sw with one write stall, then reset landing on the MEMWR cycle.
    instr(OP_SW, 0, 1);
    ifc.op = OP_SW;
    cyc("rst_fetch", 1'b1, 1'b1, C_FETCH, 1'b0);
    cyc("rst_decode", 1'b1, 1'b1, C_DEC, 1'b0);
    cyc("rst_memadr", 1'b1, 1'b1, C_MEMADR, 1'b0);
    cyc("rst_in_memwr", 1'b0, 1'b1, C_ZERO, 1'b0);
    instr(OP_J, 0, 0);
    ifc.op = OP_R;
    cyc("final_fetch", 1'b1, 1'b0, C_FWAIT, 1'b0);

    for (int unsigned i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
